transmit_ordered_set: RTL and testbench

PCS transmit path for the 1000BASE-X link: converts GMII-side TX_EN/TXD into a continuous 10-bit code-group stream with ordered-set framing (/I/, /S/, /D/, /T/, /R/) and 8b/10b running-disparity encoding. It is the counterpart of Receive. Its tx_code_group/tx_even output is the stream that, after synchronization, reaches Receive as SUDI. TX_ER, carrier extension and auto-negotiation (/C/) are out of scope.

---
 rtl/transmit_ordered_set_pkg.sv | 43 ++++
 rtl/transmit_ordered_set_encoder_8b10b.sv | 103 ++++++++++
 rtl/transmit_ordered_set.sv | 71 +++++++
 tb/tb_transmit_ordered_set.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/transmit_ordered_set_pkg.sv
// Shared 1000BASE-X PCS constants: ordered-set octets, disparity polarity, the
// transmit state enum and its transition function.
package transmit_ordered_set_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [9:0] K28_5_NEG_CODE = 10'b0011111010;

  typedef enum logic [2:0] {
    IDLE_K,
    IDLE_D,
    SOP,
    DATA,
    EPD_T,
    EPD_R,
    EPD_R2
  } tx_state_t;

  // cur_even is the parity of the slot holding the current code-group.
  function automatic tx_state_t tx_next_state(input tx_state_t cur, input logic tx_en,
                                              input logic cur_even);
    tx_state_t nxt;
    unique case (cur)
      IDLE_K:    nxt = IDLE_D;
      IDLE_D:    nxt = tx_en ? SOP : IDLE_K;
      SOP, DATA: nxt = tx_en ? DATA : EPD_T;
      EPD_T:     nxt = EPD_R;
      EPD_R:     nxt = cur_even ? EPD_R2 : IDLE_K;
      EPD_R2:    nxt = IDLE_K;
      default:   nxt = IDLE_K;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/transmit_ordered_set_encoder_8b10b.sv
// Combinational 8b/10b encoder; output bit order {a,b,c,d,e,i,f,g,h,j}.
// The tables hold the RD- column; the RD+ column is derived by complementing.
module encoder_8b10b
  import transmit_ordered_set_pkg::*;
(
  input  logic [7:0] octet,
  input  logic       is_k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six_base;
  logic [3:0] data4;
  logic [3:0] four_base;
  logic       six_unbal;
  logic       four_unbal;
  logic       rd_mid;
  logic       a7;
  logic       six_flip;
  logic       four_flip;

  assign x = octet[4:0];
  assign y = octet[7:5];

  always_comb begin
    six_base = 6'b100111;
    unique case (x)
      5'd0:  six_base = 6'b100111;
      5'd1:  six_base = 6'b011101;
      5'd2:  six_base = 6'b101101;
      5'd3:  six_base = 6'b110001;
      5'd4:  six_base = 6'b110101;
      5'd5:  six_base = 6'b101001;
      5'd6:  six_base = 6'b011001;
      5'd7:  six_base = 6'b111000;
      5'd8:  six_base = 6'b111001;
      5'd9:  six_base = 6'b100101;
      5'd10: six_base = 6'b010101;
      5'd11: six_base = 6'b110100;
      5'd12: six_base = 6'b001101;
      5'd13: six_base = 6'b101100;
      5'd14: six_base = 6'b011100;
      5'd15: six_base = 6'b010111;
      5'd16: six_base = 6'b011011;
      5'd17: six_base = 6'b100011;
      5'd18: six_base = 6'b010011;
      5'd19: six_base = 6'b110010;
      5'd20: six_base = 6'b001011;
      5'd21: six_base = 6'b101010;
      5'd22: six_base = 6'b011010;
      5'd23: six_base = 6'b111010;
      5'd24: six_base = 6'b110011;
      5'd25: six_base = 6'b100110;
      5'd26: six_base = 6'b010110;
      5'd27: six_base = 6'b110110;
      5'd28: six_base = is_k ? 6'b001111 : 6'b001110;
      5'd29: six_base = 6'b101110;
      5'd30: six_base = 6'b011110;
      5'd31: six_base = 6'b101011;
      default: six_base = 6'b100111;
    endcase
  end

  // D.7 is balanced but still has distinct RD-/RD+ forms (111000 / 000111).
  assign six_unbal = ($countones(six_base) != 3);
  assign six_flip  = rd_in && (six_unbal || (!is_k && x == 5'd7));
  assign rd_mid    = rd_in ^ six_unbal;

  // Alternate D.x.7 avoids a run of five identical bits across the sub-block boundary.
  assign a7 = !is_k && (y == 3'd7) &&
              ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
               ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));

  always_comb begin
    data4 = 4'b1011;
    unique case (y)
      3'd0: data4 = 4'b1011;
      3'd1: data4 = 4'b1001;
      3'd2: data4 = 4'b0101;
      3'd3: data4 = 4'b1100;
      3'd4: data4 = 4'b1101;
      3'd5: data4 = 4'b1010;
      3'd6: data4 = 4'b0110;
      3'd7: data4 = 4'b1110;
      default: data4 = 4'b1011;
    endcase
    four_base = data4;
    if (y == 3'd7 && (is_k || a7))
      four_base = 4'b0111;
    else if (is_k && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
      four_base = ~data4;
  end

  assign four_unbal = ($countones(four_base) != 2);
  assign four_flip  = rd_mid && (is_k || four_unbal || y == 3'd3);
  assign rd_out     = rd_mid ^ four_unbal;

  assign code = {six_flip ? ~six_base : six_base, four_flip ? ~four_base : four_base};

endmodule

// File: rtl/transmit_ordered_set.sv
// 1000BASE-X PCS transmit: frames GMII TX_EN/TXD into /I/ /S/ /D/ /T/ /R/ ordered
// sets and drives one registered 8b/10b code-group per clock.
module transmit_ordered_set
  import transmit_ordered_set_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic [7:0] TXD,
  output logic [9:0] tx_code_group,
  output logic       tx_even
);

  tx_state_t  state_reg;
  tx_state_t  state_next;
  logic       rd_reg;        // disparity the current code-group was encoded from
  logic       rd_after_reg;  // disparity after the current code-group
  logic [7:0] enc_octet;
  logic       enc_is_k;
  logic [9:0] enc_code;
  logic       enc_rd_out;

  assign state_next = tx_next_state(state_reg, TX_EN, tx_even);

  always_comb begin
    enc_octet = K28_5;
    enc_is_k  = 1'b1;
    unique case (state_next)
      IDLE_K: enc_octet = K28_5;
      IDLE_D: begin
        // rd_reg here is the disparity at the K28.5 just sent.
        enc_is_k  = 1'b0;
        enc_octet = (rd_reg == RD_POS) ? D5_6 : D16_2;
      end
      SOP:    enc_octet = K27_7;
      DATA: begin
        enc_is_k  = 1'b0;
        enc_octet = TXD;
      end
      EPD_T:  enc_octet = K29_7;
      EPD_R, EPD_R2: enc_octet = K23_7;
      default: enc_octet = K28_5;
    endcase
  end

  encoder_8b10b u_encoder (
    .octet  (enc_octet),
    .is_k   (enc_is_k),
    .rd_in  (rd_after_reg),
    .code   (enc_code),
    .rd_out (enc_rd_out)
  );

  // The reset code-group counts as K28.5 sent from RD-, leaving RD+ behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE_K;
      rd_reg        <= RD_NEG;
      rd_after_reg  <= RD_POS;
      tx_code_group <= K28_5_NEG_CODE;
      tx_even       <= 1'b1;
    end else begin
      state_reg     <= state_next;
      rd_reg        <= rd_after_reg;
      rd_after_reg  <= enc_rd_out;
      tx_code_group <= enc_code;
      tx_even       <= ~tx_even;
    end
  end

endmodule

// File: tb/tb_transmit_ordered_set.sv
// Scoreboard bench for transmit_ordered_set: a table-driven reference model pushes
// the expected code-group/parity at each drive, a monitor pops and compares.
module tb_transmit_ordered_set;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       TX_EN = 1'b0;
  logic [7:0] TXD = 8'h00;
  logic [9:0] tx_code_group;
  logic       tx_even;

  transmit_ordered_set dut (
    .clk           (clk),
    .reset         (reset),
    .TX_EN         (TX_EN),
    .TXD           (TXD),
    .tx_code_group (tx_code_group),
    .tx_even       (tx_even)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] code;
    logic       even;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_tx  = 0;

  localparam int M_IK = 0, M_ID = 1, M_S = 2, M_D = 3, M_T = 4, M_R = 5, M_R2 = 6;
  int   m_state;
  logic m_even;
  logic m_rd;    // disparity after the last modelled code-group
  logic m_rd_k;  // disparity entering the most recent K28.5

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Returns {rd_out, code}; both disparity columns written out explicitly.
  function automatic logic [10:0] ref_enc(input logic [7:0] o, input logic k, input logic rd);
    logic [11:0] t6;
    logic [7:0]  t4;
    logic [5:0]  s;
    logic [3:0]  f;
    logic        rdm;
    logic        rdo;
    logic [4:0]  x;
    logic [2:0]  y;
    x = o[4:0];
    y = o[7:5];
    case (x)
      0: t6 = 12'b100111_011000;   1: t6 = 12'b011101_100010;
      2: t6 = 12'b101101_010010;   3: t6 = 12'b110001_110001;
      4: t6 = 12'b110101_001010;   5: t6 = 12'b101001_101001;
      6: t6 = 12'b011001_011001;   7: t6 = 12'b111000_000111;
      8: t6 = 12'b111001_000110;   9: t6 = 12'b100101_100101;
      10: t6 = 12'b010101_010101;  11: t6 = 12'b110100_110100;
      12: t6 = 12'b001101_001101;  13: t6 = 12'b101100_101100;
      14: t6 = 12'b011100_011100;  15: t6 = 12'b010111_101000;
      16: t6 = 12'b011011_100100;  17: t6 = 12'b100011_100011;
      18: t6 = 12'b010011_010011;  19: t6 = 12'b110010_110010;
      20: t6 = 12'b001011_001011;  21: t6 = 12'b101010_101010;
      22: t6 = 12'b011010_011010;  23: t6 = 12'b111010_000101;
      24: t6 = 12'b110011_001100;  25: t6 = 12'b100110_100110;
      26: t6 = 12'b010110_010110;  27: t6 = 12'b110110_001001;
      28: t6 = k ? 12'b001111_110000 : 12'b001110_001110;
      29: t6 = 12'b101110_010001;  30: t6 = 12'b011110_100001;
      default: t6 = 12'b101011_010100;
    endcase
    s   = rd ? t6[5:0] : t6[11:6];
    rdm = ($countones(s) == 3) ? rd : ~rd;
    if (k) begin
      case (y)
        0: t4 = 8'b1011_0100;  1: t4 = 8'b0110_1001;
        2: t4 = 8'b1010_0101;  3: t4 = 8'b1100_0011;
        4: t4 = 8'b1101_0010;  5: t4 = 8'b0101_1010;
        6: t4 = 8'b1001_0110;  default: t4 = 8'b0111_1000;
      endcase
    end else begin
      case (y)
        0: t4 = 8'b1011_0100;  1: t4 = 8'b1001_1001;
        2: t4 = 8'b0101_0101;  3: t4 = 8'b1100_0011;
        4: t4 = 8'b1101_0010;  5: t4 = 8'b1010_1010;
        6: t4 = 8'b0110_0110;
        default: begin
          if ((!rdm && (x == 17 || x == 18 || x == 20)) || (rdm && (x == 11 || x == 13 || x == 14)))
            t4 = 8'b0111_1000;
          else
            t4 = 8'b1110_0001;
        end
      endcase
    end
    f   = rdm ? t4[3:0] : t4[7:4];
    rdo = ($countones(f) == 2) ? rdm : ~rdm;
    return {rdo, s, f};
  endfunction

  task automatic model_reset();
    m_state = M_IK;
    m_even  = 1'b1;
    m_rd    = 1'b1;
    m_rd_k  = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [7:0] d);
    int          nxt;
    logic [7:0]  o;
    logic        k;
    logic [10:0] r;
    case (m_state)
      M_IK:     nxt = M_ID;
      M_ID:     nxt = en ? M_S : M_IK;
      M_S, M_D: nxt = en ? M_D : M_T;
      M_T:      nxt = M_R;
      M_R:      nxt = m_even ? M_R2 : M_IK;
      default:  nxt = M_IK;
    endcase
    k = 1'b1;
    case (nxt)
      M_ID:       begin k = 1'b0; o = m_rd_k ? 8'hC5 : 8'h50; end
      M_S:        o = 8'hFB;
      M_D:        begin k = 1'b0; o = d; end
      M_T:        o = 8'hFD;
      M_R, M_R2:  o = 8'hF7;
      default:    o = 8'hBC;
    endcase
    r = ref_enc(o, k, m_rd);
    if (nxt == M_IK) m_rd_k = m_rd;
    m_rd    = r[10];
    m_even  = ~m_even;
    m_state = nxt;
    exp_q.push_back({r[9:0], m_even});
  endtask

  // Called at a falling edge; the next rising edge samples these inputs.
  task automatic drive(input logic en, input logic [7:0] d);
    TX_EN = en;
    TXD   = d;
    model_step(en, d);
    @(negedge clk);
  endtask

  task automatic idle_until(input int want);
    for (int i = 0; i < 8 && m_state != want; i++) drive(1'b0, 8'h00);
    if (m_state != want) check_val("align_timeout", m_state, want);
  endtask

  task automatic send_frame(input logic [7:0] octs[$]);
    foreach (octs[i]) drive(1'b1, octs[i]);
    drive(1'b0, 8'h00);
  endtask

  task automatic reset_mid_frame();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_rst_code", tx_code_group, 10'b0011111010);
    check_val("async_rst_even", tx_even, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tx++;
      $display("tx %0d: code=%b even=%b exp=%b/%b", n_tx, tx_code_group, tx_even,
               mon_e.code, mon_e.even);
      check_val("code_group", tx_code_group, mon_e.code);
      check_val("tx_even", tx_even, mon_e.even);
    end
  end

  initial begin
    logic [7:0] q[$];
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset_code", tx_code_group, 10'b0011111010);
    check_val("reset_even", tx_even, 1'b1);
    reset = 1'b0;

    repeat (8) drive(1'b0, 8'h00);

    // TX_EN aligned to IDLE_D, odd data count
    idle_until(M_ID);
    q = {8'h55, 8'h55, 8'hD5, 8'hAA};
    send_frame(q);

    // TX_EN rising on an even slot: first octet dropped
    idle_until(M_IK);
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(q);

    // even data count
    idle_until(M_ID);
    q = {8'hAA, 8'hBB, 8'hCC};
    send_frame(q);

    // minimum frame
    idle_until(M_ID);
    q = {8'h55};
    send_frame(q);

    // D3.0 leaves RD+ at idle entry: expect K28.5+ then /I1/
    idle_until(M_ID);
    q = {8'h00, 8'h03};
    send_frame(q);
    repeat (6) drive(1'b0, 8'h00);

    // reset in the middle of DATA
    idle_until(M_ID);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h12);
    drive(1'b1, 8'h34);
    reset_mid_frame();
    repeat (6) drive(1'b0, 8'h00);

    // random frames, some with TX_EN reasserted during the end-of-packet sets
    for (int f = 0; f < 12; f++) begin
      idle_until(($urandom_range(0, 1) == 0) ? M_IK : M_ID);
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) q.push_back(8'($urandom_range(0, 255)));
      send_frame(q);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive(1'b1, 8'($urandom_range(0, 255)));
    end
    repeat (4) drive(1'b0, 8'h00);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) check_val("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
